snake_body_tracker: RTL and testbench
=====================================

Name: snake_body_tracker

Overview:
- Parametrised successor to the fixed 32x32 snake body block. Holds the snake as a circular queue of segment coordinates plus a registered occupancy bitmap for the VGA renderer.
- Computes the next head position internally, including wrap and reversal filtering, and handles apple growth, length saturation and self-collision.
- Sits between the input/direction logic and the display/apple-generator blocks. It replaces the separate head and body modules.

Parameters:
- WIDTH, 32, playfield columns (2..128).
- HEIGHT, 32, playfield rows (2..128).
- STARTX, 2, reset head column, 0..WIDTH-1.
- STARTY, 2, reset head row; STARTY+START_LEN-1 must be at most HEIGHT-1.
- START_LEN, 3, reset length in segments (at least 2).
- MAX_LEN, 64, queue depth and maximum length.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- step  in  1  one-cycle pulse: advance the snake one cell.
- dir  in  2  requested direction (dir_t).
- restart  in  1  leave DEAD and reload the reset image.
- apple_x  in  7  apple column.
- apple_y  in  7  apple row.
- head_x  out  7  current head column.
- head_y  out  7  current head row.
- body  out  WIDTH*HEIGHT  occupancy bitmap, packed [WIDTH-1:0][HEIGHT-1:0].
- length  out  LW  current segment count, LW = $clog2(MAX_LEN+1).
- eaten  out  1  one-cycle pulse on the step that consumed the apple.
- dead  out  1  high while in the DEAD state.

Behaviour:
- Reset (async assert, sync deassert at the top level):
  - state IDLE, cur_dir UP.
  - Queue holds (STARTX, STARTY..STARTY+START_LEN-1), with head at STARTY.
  - body holds exactly those bits; length=START_LEN; eaten=0, dead=0.
- States:
  - IDLE: the first step moves the snake and enters RUN.
  - RUN: every step moves the snake.
  - DEAD: step is ignored; restart reloads the reset image and enters IDLE.
  - restart in IDLE or RUN has the same effect as in DEAD.
  - restart has priority over step in the same cycle.
- Direction: dir is applied on step unless it is the exact opposite of cur_dir. In that case cur_dir is kept.
- Next head: one cell from the head in cur_dir. Wrap: column 0 going LEFT goes to WIDTH-1; WIDTH-1 going RIGHT goes to 0. Rows wrap the same way with HEIGHT.
- Grow: grow = (next == apple).
- Collision: body[next] && !(next == tail && !grow). The cell the tail is vacating is legal to enter.
- On collision: enter DEAD. body, queue and length freeze at their pre-step values; no push or pop.
- Otherwise:
  - Push next as the new head; set body[next].
  - If !grow, or length == MAX_LEN: pop the tail and clear its bit. The clear never wipes the new head (the tail-equals-next case).
  - If grow: length += 1, saturating at MAX_LEN. eaten=1 for that cycle.
- Latency: all outputs are registered and reflect a step one clock after the step edge. step asserted on consecutive cycles is legal.
- Queue uses head/tail pointers modulo MAX_LEN. Overflow is impossible by construction; assert this in simulation.
- Coordinates are 7 bits; upper bits above $clog2(WIDTH) read as zero.

Optional Feature:
- Macro SNAKE_WALL_DEATH_EN.
- Defined: stepping off any edge gives dead instead of wrapping; collision rules are otherwise unchanged.
- Undefined: toroidal wrap as above.

Decomposition:
- Package snake_pkg:
  - dir_t enum UP=2'b00, RIGHT=2'b01, LEFT=2'b10, DOWN=2'b11.
  - state_t enum IDLE, RUN, DEAD.
  - function is_opposite(dir_t, dir_t).
  - coord width constant 7.
- Sub-module snake_seg_fifo:
  - Parametrised circular coordinate queue with MAX_LEN depth.
  - push, pop and reload ports; outputs head, tail and count.
  - Reset preloads the start segments.

Test Plan:
- Reset with defaults → body bits (2,2),(2,3),(2,4) only, length=3, head=(2,2), dead=0.
- 3 steps UP, apple at (10,10) → heads (2,1),(2,0),(2,31); popcount stays 3; last body set {(2,31),(2,0),(2,1)}.
- Apple at (2,1), step UP → eaten pulses one cycle, length=4, tail stays (2,4), popcount 4.
- Head moving RIGHT, dir=LEFT on step → head x+1, cur_dir stays RIGHT.
- Length 4 snake (head (5,5), body (6,5),(6,6),(5,6)), step DOWN into tail (5,6) with no apple → not dead, popcount 4.
- Length 5, turn into own body → dead=1; body frozen across 3 further steps; restart → reset image, state IDLE.
- With SNAKE_WALL_DEATH_EN, head (2,0) stepping UP → dead=1, head stays (2,0).

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body tracker.
// SNAKE_WALL_DEATH_EN (in snake_body_tracker) selects wall death over toroidal wrap.
package snake_pkg;

   localparam int unsigned CoordW = 7;

   typedef logic [CoordW-1:0] coord_t;

   typedef enum logic [1:0] {
      Up    = 2'b00,
      Right = 2'b01,
      Left  = 2'b10,
      Down  = 2'b11
   } dir_t;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDead
   } state_t;

   // Opposite directions differ in both encoding bits.
   function automatic logic is_opposite(dir_t a, dir_t b);
      return (a ^ b) == 2'b11;
   endfunction

endpackage

// File: rtl/snake_seg_fifo.sv
// Circular queue of segment coordinates; head is the newest entry, tail the oldest.
// Reset and reload both preload the vertical start snake with its head at StartY.
module snake_seg_fifo
   import snake_pkg::*;
#(
   parameter int unsigned MaxLen   = 64,
   parameter int unsigned StartX   = 2,
   parameter int unsigned StartY   = 2,
   parameter int unsigned StartLen = 3,
   localparam int unsigned PtrW    = (MaxLen > 1) ? $clog2(MaxLen) : 1,
   localparam int unsigned CntW    = $clog2(MaxLen + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  logic            pop_i,
   input  logic            reload_i,
   input  coord_t          push_x_i,
   input  coord_t          push_y_i,
   output coord_t          head_x_o,
   output coord_t          head_y_o,
   output coord_t          tail_x_o,
   output coord_t          tail_y_o,
   output logic [CntW-1:0] count_o
);

   coord_t            mem_x_q [MaxLen];
   coord_t            mem_y_q [MaxLen];
   logic [PtrW-1:0]   hd_q, tl_q;
   logic [CntW-1:0]   cnt_q;
   logic [PtrW-1:0]   hd_inc;

   function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
      return (p == PtrW'(MaxLen - 1)) ? '0 : p + 1'b1;
   endfunction

   assign hd_inc = ptr_inc(hd_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < MaxLen; i++) begin
            mem_x_q[i] <= (i < StartLen) ? coord_t'(StartX) : '0;
            mem_y_q[i] <= (i < StartLen) ? coord_t'(StartY + StartLen - 1 - i) : '0;
         end
         hd_q  <= PtrW'(StartLen - 1);
         tl_q  <= '0;
         cnt_q <= CntW'(StartLen);
      end else if (reload_i) begin
         for (int unsigned i = 0; i < MaxLen; i++) begin
            mem_x_q[i] <= (i < StartLen) ? coord_t'(StartX) : '0;
            mem_y_q[i] <= (i < StartLen) ? coord_t'(StartY + StartLen - 1 - i) : '0;
         end
         hd_q  <= PtrW'(StartLen - 1);
         tl_q  <= '0;
         cnt_q <= CntW'(StartLen);
      end else begin
         // When full, hd_inc aliases the slot of the tail being popped this cycle.
         if (push_i) begin
            hd_q          <= hd_inc;
            mem_x_q[hd_inc] <= push_x_i;
            mem_y_q[hd_inc] <= push_y_i;
         end
         if (pop_i) begin
            tl_q <= ptr_inc(tl_q);
         end
         if (push_i && !pop_i) begin
            cnt_q <= cnt_q + 1'b1;
         end else if (!push_i && pop_i) begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign head_x_o = mem_x_q[hd_q];
   assign head_y_o = mem_y_q[hd_q];
   assign tail_x_o = mem_x_q[tl_q];
   assign tail_y_o = mem_y_q[tl_q];
   assign count_o  = cnt_q;

   no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && !pop_i && !reload_i && (cnt_q == CntW'(MaxLen))));
   no_underflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(pop_i && !push_i && !reload_i && (cnt_q == '0)));

endmodule

// File: rtl/snake_body_tracker.sv
// Snake head/body tracker: segment queue, occupancy bitmap, growth and collision.
// Define SNAKE_WALL_DEATH_EN to die on leaving the playfield instead of wrapping.
module snake_body_tracker
   import snake_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned HEIGHT    = 32,
   parameter int unsigned STARTX    = 2,
   parameter int unsigned STARTY    = 2,
   parameter int unsigned START_LEN = 3,
   parameter int unsigned MAX_LEN   = 64,
   localparam int unsigned LW       = $clog2(MAX_LEN + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          step_i,
   input  logic [1:0]                    dir_i,
   input  logic                          restart_i,
   input  logic [CoordW-1:0]             apple_x_i,
   input  logic [CoordW-1:0]             apple_y_i,
   output logic [CoordW-1:0]             head_x_o,
   output logic [CoordW-1:0]             head_y_o,
   output logic [WIDTH-1:0][HEIGHT-1:0]  body_o,
   output logic [LW-1:0]                 length_o,
   output logic                          eaten_o,
   output logic                          dead_o
);

   localparam int unsigned XW = $clog2(WIDTH);
   localparam int unsigned YW = $clog2(HEIGHT);

   function automatic logic [WIDTH-1:0][HEIGHT-1:0] start_body();
      logic [WIDTH-1:0][HEIGHT-1:0] img;
      img = '0;
      for (int unsigned i = 0; i < START_LEN; i++) begin
         img[STARTX][STARTY + i] = 1'b1;
      end
      return img;
   endfunction

   // Release the internal reset synchronously to clk_i.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rst_sync_q <= '0;
      else         rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   state_t                       state_q, state_d;
   dir_t                         cur_dir_q, cur_dir_d, eff_dir;
   logic [WIDTH-1:0][HEIGHT-1:0] body_q, body_d;
   logic                         eaten_q, eaten_d;
   coord_t                       hx, hy, tx, ty, nx, ny;
   logic [LW-1:0]                count;
   logic                         push, pop, reload;
   logic                         grow, hit, off_edge, advance;

   snake_seg_fifo #(
      .MaxLen  (MAX_LEN),
      .StartX  (STARTX),
      .StartY  (STARTY),
      .StartLen(START_LEN)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .reload_i(reload),
      .push_x_i(nx),
      .push_y_i(ny),
      .head_x_o(hx),
      .head_y_o(hy),
      .tail_x_o(tx),
      .tail_y_o(ty),
      .count_o (count)
   );

   always_comb begin
      eff_dir = is_opposite(dir_t'(dir_i), cur_dir_q) ? cur_dir_q : dir_t'(dir_i);
      nx = hx;
      ny = hy;
      case (eff_dir)
         Up:    ny = (hy == '0) ? coord_t'(HEIGHT - 1) : hy - 1'b1;
         Down:  ny = (hy == coord_t'(HEIGHT - 1)) ? '0 : hy + 1'b1;
         Left:  nx = (hx == '0) ? coord_t'(WIDTH - 1) : hx - 1'b1;
         Right: nx = (hx == coord_t'(WIDTH - 1)) ? '0 : hx + 1'b1;
      endcase
`ifdef SNAKE_WALL_DEATH_EN
      off_edge = ((eff_dir == Up)    && (hy == '0))                   ||
                 ((eff_dir == Down)  && (hy == coord_t'(HEIGHT - 1))) ||
                 ((eff_dir == Left)  && (hx == '0))                   ||
                 ((eff_dir == Right) && (hx == coord_t'(WIDTH - 1)));
`else
      off_edge = 1'b0;
`endif
      grow    = (nx == apple_x_i) && (ny == apple_y_i);
      // The vacating tail cell is enterable unless the tail stays put to grow.
      hit     = body_q[nx[XW-1:0]][ny[YW-1:0]] && !((nx == tx) && (ny == ty) && !grow);
      advance = step_i && (state_q != StDead);
   end

   always_comb begin
      state_d   = state_q;
      cur_dir_d = cur_dir_q;
      body_d    = body_q;
      eaten_d   = 1'b0;
      push      = 1'b0;
      pop       = 1'b0;
      reload    = 1'b0;
      if (restart_i) begin
         state_d   = StIdle;
         cur_dir_d = Up;
         body_d    = start_body();
         reload    = 1'b1;
      end else if (advance) begin
         cur_dir_d = eff_dir;
         if (hit || off_edge) begin
            state_d = StDead;
         end else begin
            state_d = StRun;
            push    = 1'b1;
            pop     = !grow || (count == LW'(MAX_LEN));
            eaten_d = grow;
            if (pop) body_d[tx[XW-1:0]][ty[YW-1:0]] = 1'b0;
            body_d[nx[XW-1:0]][ny[YW-1:0]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cur_dir_q <= Up;
         body_q    <= start_body();
         eaten_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_dir_q <= cur_dir_d;
         body_q    <= body_d;
         eaten_q   <= eaten_d;
      end
   end

   assign head_x_o = hx;
   assign head_y_o = hy;
   assign body_o   = body_q;
   assign length_o = count;
   assign eaten_o  = eaten_q;
   assign dead_o   = (state_q == StDead);

endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboard bench for snake_body_tracker against a queue-based reference snake.
// Honours SNAKE_WALL_DEATH_EN in its model when the design is built with it.
module tb_snake_body_tracker;
   localparam int W  = 12;
   localparam int H  = 10;
   localparam int SX = 2;
   localparam int SY = 2;
   localparam int SL = 3;
   localparam int ML = 8;
   localparam int LW = $clog2(ML + 1);

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 step = 1'b0;
   logic                 restart = 1'b0;
   logic [1:0]           dir = 2'd0;
   logic [6:0]           ax = 7'd0, ay = 7'd0;
   logic [6:0]           hx, hy;
   logic [W-1:0][H-1:0]  body;
   logic [LW-1:0]        len;
   logic                 eaten, dead;

   always #5 clk = ~clk;

   snake_body_tracker #(
      .WIDTH(W), .HEIGHT(H), .STARTX(SX), .STARTY(SY), .START_LEN(SL), .MAX_LEN(ML)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .step_i(step), .dir_i(dir), .restart_i(restart),
      .apple_x_i(ax), .apple_y_i(ay), .head_x_o(hx), .head_y_o(hy), .body_o(body),
      .length_o(len), .eaten_o(eaten), .dead_o(dead)
   );

   typedef struct {
      int                  hx, hy, len;
      bit                  dead, eaten;
      logic [W-1:0][H-1:0] body;
   } exp_t;

   exp_t exp_q[$];
   int   passed = 0;
   int   total  = 0;

   // Reference snake: index 0 is the head. Directions: 0 up, 1 right, 2 left, 3 down.
   int mx[$], my[$];
   int mdir;
   bit mdead;

   function automatic int opp(int d);
      case (d)
         0: return 3;
         1: return 2;
         2: return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int ddx(int d);
      return (d == 1) ? 1 : (d == 2) ? -1 : 0;
   endfunction

   function automatic int ddy(int d);
      return (d == 3) ? 1 : (d == 0) ? -1 : 0;
   endfunction

   task automatic model_reset();
      mx = {};
      my = {};
      for (int i = 0; i < SL; i++) begin
         mx.push_back(SX);
         my.push_back(SY + i);
      end
      mdir  = 0;
      mdead = 1'b0;
   endtask

   function automatic exp_t snap(bit eat);
      exp_t e;
      e.body = '0;
      foreach (mx[i]) e.body[mx[i]][my[i]] = 1'b1;
      e.hx    = mx[0];
      e.hy    = my[0];
      e.len   = mx.size();
      e.dead  = mdead;
      e.eaten = eat;
      return e;
   endfunction

   task automatic model_cycle(input bit stp, input bit rst, input int d,
                              input int axv, input int ayv, output bit eat);
      int  rx, ry, nx, ny;
      bit  grow, hit, full;
      eat = 1'b0;
      if (rst) begin
         model_reset();
      end else if (stp && !mdead) begin
         if (d != opp(mdir)) mdir = d;
         rx = mx[0] + ddx(mdir);
         ry = my[0] + ddy(mdir);
         nx = (rx + W) % W;
         ny = (ry + H) % H;
         grow = (nx == axv) && (ny == ayv);
         hit  = 1'b0;
         foreach (mx[i])
            if (mx[i] == nx && my[i] == ny && !(i == mx.size() - 1 && !grow)) hit = 1'b1;
`ifdef SNAKE_WALL_DEATH_EN
         if (rx < 0 || rx >= W || ry < 0 || ry >= H) hit = 1'b1;
`endif
         if (hit) begin
            mdead = 1'b1;
         end else begin
            full = (mx.size() == ML);
            mx.push_front(nx);
            my.push_front(ny);
            if (!grow || full) begin
               void'(mx.pop_back());
               void'(my.pop_back());
            end
            eat = grow;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
   endtask

   task automatic chk_body(input logic [W-1:0][H-1:0] act, input logic [W-1:0][H-1:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL body: got %h, expected %h at %0t", act, req, $time);
   endtask

   // One clock of stimulus; the matching expectation goes to the scoreboard.
   task automatic drive(input bit stp, input bit rst, input int d, input int axv, input int ayv);
      bit eat;
      @(negedge clk);
      step    = stp;
      restart = rst;
      dir     = 2'(d);
      ax      = 7'(axv);
      ay      = 7'(ayv);
      model_cycle(stp, rst, d, axv, ayv, eat);
      exp_q.push_back(snap(eat));
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("head_x", int'(hx), e.hx);
         chk("head_y", int'(hy), e.hy);
         chk("length", int'(len), e.len);
         chk("dead", int'(dead), int'(e.dead));
         chk("eaten", int'(eaten), int'(e.eaten));
         chk_body(body, e.body);
      end
   end

   initial begin
      exp_t r;
      int   d, eff, axv, ayv, rr;
      bit   stp, rst;
      model_reset();
      r = snap(1'b0);
      #12;
      chk("reset_head_x", int'(hx), SX);
      chk("reset_head_y", int'(hy), SY);
      chk("reset_length", int'(len), SL);
      chk("reset_dead", int'(dead), 0);
      chk("reset_eaten", int'(eaten), 0);
      chk_body(body, r.body);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Straight up through the top edge, apple out of the way.
      repeat (3) drive(1'b1, 1'b0, 0, 10, 8);
      drive(1'b0, 1'b1, 0, 10, 8);
      // Eat directly ahead, then an idle cycle.
      drive(1'b1, 1'b0, 0, 2, 1);
      drive(1'b0, 1'b0, 0, 2, 1);
      // Turn right, then request the reverse.
      drive(1'b1, 1'b0, 1, 9, 9);
      drive(1'b1, 1'b0, 2, 9, 9);
      drive(1'b1, 1'b1, 2, 9, 9);

      for (int n = 0; n < 3000; n++) begin
         rr  = $urandom_range(0, 99);
         rst = mdead ? (rr < 20) : (rr < 2);
         stp = ($urandom_range(0, 3) != 0);
         d   = $urandom_range(0, 3);
         if ($urandom_range(0, 9) < 4) begin
            eff = (d == opp(mdir)) ? mdir : d;
            axv = (mx[0] + ddx(eff) + W) % W;
            ayv = (my[0] + ddy(eff) + H) % H;
         end else begin
            axv = $urandom_range(0, W - 1);
            ayv = $urandom_range(0, H - 1);
         end
         drive(stp, rst, d, axv, ayv);
      end
      drive(1'b0, 1'b0, 0, 0, 0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
